// File: rtl/frame_max_tracker.sv
// Per-frame maximum and its index over a valid/ready sample stream (frames of FRAME_LEN or cut short by in_last).
// Latency: result registers on the final accept edge, so out_valid is high 1 clk after that accept.
// Backpressure: in_ready drops while a result waits; the next accept is one cycle after the handshake. FRAME_MAX_MIN_EN adds the minimum.
module frame_max_tracker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_len,
`ifdef FRAME_MAX_MIN_EN
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_min_idx,
`endif
    input  logic              out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;

    logic              accept;
    logic              first;
    logic              eof;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_idx;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign first    = (state == IDLE);
    assign eof      = in_last | (cnt == LAST_CNT);

    // Strict compare keeps the earliest index on ties; the final sample is included.
    assign cand_max = (first || in_data > run_max) ? in_data : run_max;
    assign cand_idx = (first || in_data > run_max) ? cnt     : run_idx;

`ifdef FRAME_MAX_MIN_EN
    logic [DATA_W-1:0] run_min;
    logic [IDX_W-1:0]  run_min_idx;
    logic [DATA_W-1:0] cand_min;
    logic [IDX_W-1:0]  cand_min_idx;

    assign cand_min     = (first || in_data < run_min) ? in_data : run_min;
    assign cand_min_idx = (first || in_data < run_min) ? cnt     : run_min_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min     <= '0;
            run_min_idx <= '0;
            out_min     <= '0;
            out_min_idx <= '0;
        end else if (accept) begin
            run_min     <= cand_min;
            run_min_idx <= cand_min_idx;
            if (eof) begin
                out_min     <= cand_min;
                out_min_idx <= cand_min_idx;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_len   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        run_max <= cand_max;
                        run_idx <= cand_idx;
                        if (eof) begin
                            out_max   <= cand_max;
                            out_idx   <= cand_idx;
                            out_len   <= {1'b0, cnt} + (IDX_W+1)'(1);
                            out_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            cnt   <= cnt + IDX_W'(1);
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_max_tracker.sv
// Randomized bench for frame_max_tracker against a queue-based frame reference model.
module tb_frame_max_tracker;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 16;
    localparam int IDX_W     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_idx;
    logic [IDX_W:0]    out_len;
    logic              out_ready = 1'b0;
`ifdef FRAME_MAX_MIN_EN
    logic [DATA_W-1:0] out_min;
    logic [IDX_W-1:0]  out_min_idx;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] smp[$];

    always #5 clk = ~clk;

    frame_max_tracker #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_max    (out_max),
        .out_idx    (out_idx),
        .out_len    (out_len),
`ifdef FRAME_MAX_MIN_EN
        .out_min    (out_min),
        .out_min_idx(out_min_idx),
`endif
        .out_ready  (out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the frame is the whole queue; first occurrence wins on ties.
    task automatic model(output int mx, output int mi, output int mn, output int mni);
        mx = -1; mi = 0; mn = 1 << DATA_W; mni = 0;
        for (int i = 0; i < smp.size(); i++) begin
            if (int'(smp[i]) > mx) begin mx = smp[i]; mi = i; end
            if (int'(smp[i]) < mn) begin mn = smp[i]; mni = i; end
        end
    endtask

    task automatic check_result(input string tag);
        int mx, mi, mn, mni;
        model(mx, mi, mn, mni);
        check_eq({tag, ".valid"}, 32'(out_valid), 1);
        check_eq({tag, ".max"}, 32'(out_max), mx);
        check_eq({tag, ".idx"}, 32'(out_idx), mi);
        check_eq({tag, ".len"}, 32'(out_len), smp.size());
`ifdef FRAME_MAX_MIN_EN
        check_eq({tag, ".min"}, 32'(out_min), mn);
        check_eq({tag, ".min_idx"}, 32'(out_min_idx), mni);
`endif
    endtask

    // Drives smp as one frame from a negedge, holds the result hold_cycles with junk inputs, then releases.
    task automatic run_frame(input string tag, input int hold_cycles, input bit gaps);
        int n = smp.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    in_valid = 1'b0; in_last = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = smp[i];
            in_last  = (i == n - 1) ? ((n < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            check_eq({tag, ".in_ready"}, 32'(in_ready), 1);
            if (i > 0) check_eq({tag, ".early_valid"}, 32'(out_valid), 0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_eq({tag, ".in_ready_hold"}, 32'(in_ready), 0);
        check_result(tag);
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            @(negedge clk);
            check_eq({tag, ".stall_in_ready"}, 32'(in_ready), 0);
            check_result({tag, ".stall"});
        end
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({tag, ".after_hs_valid"}, 32'(out_valid), 0);
        check_eq({tag, ".after_hs_in_ready"}, 32'(in_ready), 1);
        begin
            int mx, mi, mn, mni;
            model(mx, mi, mn, mni);
            check_eq({tag, ".after_hs_max_kept"}, 32'(out_max), mx);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst.valid", 32'(out_valid), 0);
        check_eq("rst.max", 32'(out_max), 0);
        check_eq("rst.idx", 32'(out_idx), 0);
        check_eq("rst.len", 32'(out_len), 0);
        check_eq("rst.in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        smp = {};
        smp.push_back(3); smp.push_back(9); smp.push_back(1); smp.push_back(9);
        while (smp.size() < FRAME_LEN) smp.push_back(2);
        run_frame("full16", 0, 1'b0);

        smp = {8'd5, 8'd7, 8'd4};
        run_frame("short3", 0, 1'b0);

        smp = {8'd10, 8'd20, 8'd30, 8'd20};
        run_frame("stall5", 5, 1'b0);

        smp = {8'd8, 8'd2, 8'd2, 8'd9};
        run_frame("minmax", 1, 1'b0);

        smp = {8'hFF};
        run_frame("single", 2, 1'b0);

        // Abort a partial frame with reset; out_max still shows 0xFF from before.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'hF0 + DATA_W'(i); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.valid", 32'(out_valid), 0);
        check_eq("midrst.max", 32'(out_max), 0);
        check_eq("midrst.len", 32'(out_len), 0);
        check_eq("midrst.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        smp = {};
        for (int i = 0; i < FRAME_LEN; i++) smp.push_back(DATA_W'(i == 5 ? 200 : i));
        run_frame("fresh", 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, FRAME_LEN);
            smp = {};
            for (int i = 0; i < n; i++) smp.push_back(DATA_W'($urandom_range(0, 15)));
            run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
